// File: rtl/min_max_pkg.sv
// min_max_pkg: display-mode encoding and default sizing shared by the min/max display blocks.
package min_max_pkg;

    typedef enum logic [1:0] {
        COM_NORMAL = 2'b00,
        COM_LINEAR = 2'b01,
        COM_OFF    = 2'b10,
        COM_ON     = 2'b11
    } com_t;

    localparam int VALSIZE_DEF     = 4;
    localparam int OSC_DIV_DEF     = 8;
    localparam int OSC_DUTY_DEF    = 2;
    localparam int SYNC_STAGES_DEF = 2;

    function automatic com_t com_next(input com_t c);
        return com_t'(c + 2'd1);
    endfunction

endpackage

// File: rtl/button_sync_edge.sv
// button_sync_edge: synchronizes an asynchronous button and emits a registered 1-cycle pulse per press.
module button_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_i,
    output logic pulse_o
);

    logic [SYNC_STAGES-1:0] sync_q, fill_q;
    logic                   prev_q, arm_q, pulse_q;
    logic                   btn_s;

    assign btn_s   = sync_q[SYNC_STAGES-1];
    assign pulse_o = pulse_q;

    // arm_q only sets once a genuine low has been seen, so a button held through reset stays silent
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q  <= '0;
            fill_q  <= '0;
            prev_q  <= 1'b0;
            arm_q   <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], btn_i};
            fill_q  <= {fill_q[SYNC_STAGES-2:0], 1'b1};
            prev_q  <= btn_s;
            arm_q   <= arm_q | (fill_q[SYNC_STAGES-1] & ~btn_s);
            pulse_q <= arm_q & btn_s & ~prev_q;
        end
    end

endmodule

// File: rtl/min_max_input_ctrl.sv
// min_max_input_ctrl: turns buttons/switches into registered com/min/max/val/osc inputs for the display stage.
module min_max_input_ctrl
    import min_max_pkg::*;
#(
    parameter int VALSIZE     = VALSIZE_DEF,
    parameter int OSC_DIV     = OSC_DIV_DEF,
    parameter int OSC_DUTY    = OSC_DUTY_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               inc_i,
    input  logic               dec_i,
    input  logic               mode_i,
    input  logic [VALSIZE-1:0] min_i,
    input  logic [VALSIZE-1:0] max_i,
    output logic [1:0]         com_o,
    output logic [VALSIZE-1:0] min_o,
    output logic [VALSIZE-1:0] max_o,
    output logic [VALSIZE-1:0] val_o,
    output logic               osc_o
);

    localparam int CW = (OSC_DIV > 1) ? $clog2(OSC_DIV) : 1;

    logic               inc_p, dec_p, mode_p;
    com_t               com_q, com_d;
    logic [VALSIZE-1:0] min_q, min_d, max_q, max_d, val_q, val_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               osc_q, osc_d;

    button_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_inc (
        .clk_i(clk_i), .rst_ni(rst_ni), .btn_i(inc_i), .pulse_o(inc_p)
    );
    button_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_dec (
        .clk_i(clk_i), .rst_ni(rst_ni), .btn_i(dec_i), .pulse_o(dec_p)
    );
    button_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_mode (
        .clk_i(clk_i), .rst_ni(rst_ni), .btn_i(mode_i), .pulse_o(mode_p)
    );

    // clamping wins over button pulses, which are then simply dropped
    always_comb begin
        min_d = (min_i <= max_i) ? min_i : min_q;
        max_d = (min_i <= max_i) ? max_i : max_q;
        val_d = (val_q < min_q)                      ? min_q :
                (val_q > max_q)                      ? max_q :
                (com_q[1] || (inc_p && dec_p))       ? val_q :
                (inc_p && val_q < max_q)             ? val_q + 1'b1 :
                (!inc_p && dec_p && val_q > min_q)   ? val_q - 1'b1 : val_q;
        com_d = mode_p ? com_next(com_q) : com_q;
        cnt_d = (cnt_q == CW'(OSC_DIV - 1)) ? '0 : cnt_q + 1'b1;
        osc_d = cnt_q < CW'(OSC_DUTY);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            com_q <= COM_NORMAL;
            min_q <= '0;
            max_q <= '1;
            val_q <= '0;
            cnt_q <= '0;
            osc_q <= 1'b0;
        end else begin
            com_q <= com_d;
            min_q <= min_d;
            max_q <= max_d;
            val_q <= val_d;
            cnt_q <= cnt_d;
            osc_q <= osc_d;
        end
    end

    assign com_o = com_q;
    assign min_o = min_q;
    assign max_o = max_q;
    assign val_o = val_q;
    assign osc_o = osc_q;

endmodule
